prog_loader: RTL and testbench
==============================

# prog_loader

Program loader and instruction store for the 4-bit CPU. Accepts a 16-byte program plus checksum over a valid/ready byte stream and writes it into a 16×8 instruction memory. Serves combinational instruction fetches on the CPU's `adr`/`instr` port. Holds the CPU in reset until a load completes with a correct checksum.

## Interface
Parameters:
- `CHECK_EN`, default 1: 1 = a checksum byte follows the 16 data bytes and is verified; 0 = no checksum byte, RUN entered straight after byte 15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `load_req`  in  1  one-cycle pulse; starts or restarts a program load.
- `in_data`  in  8  program byte from host.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `adr`  in  4  CPU fetch address (PC).
- `instr`  out  8  instruction at `adr`.
- `cpu_reset`  out  1  reset to the CPU; high whenever state ≠ RUN.
- `loaded`  out  1  a verified program is present and running.
- `err`  out  1  last load failed its checksum.

## Operation
- States: IDLE, LOAD, CHECK, RUN, ERR.
- Reset:
  - state = IDLE; all 16 memory words = 8'h00 (nop program); wr_ptr = 0; sum = 0.
  - `cpu_reset` = 1, `loaded` = 0, `err` = 0, `in_ready` = 0.
- `load_req` in any state:
  - next state = LOAD; wr_ptr = 0; sum = 0; `err` = 0; `loaded` = 0.
  - Memory contents are not cleared; they are overwritten by the new program.
- Byte acceptance:
  - A byte is accepted only on a cycle where `in_valid` && `in_ready`.
  - `in_ready` = (state == LOAD || state == CHECK) && !`load_req` (combinational).
- LOAD, byte accepted:
  - mem[wr_ptr] = `in_data`; sum = sum + `in_data` (8-bit, mod 256); wr_ptr increments.
  - When wr_ptr == 15 is written: next state = CHECK if `CHECK_EN`, else RUN. The 4-bit wr_ptr wraps to 0; this is harmless.
- CHECK, byte accepted:
  - `in_data` == sum → RUN, `loaded` = 1.
  - Otherwise → ERR, `err` = 1.
  - The checksum byte is never written to memory.
- RUN: `cpu_reset` = 0. Only `load_req` leaves RUN.
- ERR: `cpu_reset` = 1, `err` = 1. Only `load_req` leaves ERR.
- IDLE: `cpu_reset` = 1. Only `load_req` leaves IDLE.
- Read port:
  - `instr` = mem[`adr`], combinational, valid in every state.
  - During LOAD the CPU is held in reset, so torn reads do not matter.
- `load_req` together with `in_valid`: `load_req` wins; the byte is not accepted (`in_ready` is 0 that cycle).

## Timing
- `cpu_reset`, `loaded`, `err` are registered and change on the edge that enters or leaves the state.
- Checksum byte accepted at edge N:
  - `cpu_reset` falls after edge N; CPU sees reset low from cycle N+1 and fetches `adr` 0 first.
- `load_req` sampled at edge N while in RUN:
  - `cpu_reset` high after edge N; first data byte can be accepted at edge N+1.
- Throughput: one byte per cycle with `in_valid` held high; a full load takes 17 accepted bytes minimum (16 with `CHECK_EN` = 0).
- Write-to-read: a byte written at edge N is visible on `instr` from cycle N+1 when `adr` matches.
- `reset` mid-load: abandons the load, clears memory, returns to IDLE on the same edge.

## Structure
- Shared package `td4_pkg`:
  - `ADR_W` = 4, `INSTR_W` = 8, `MEM_DEPTH` = 16.
  - State enum `loader_state_t` {IDLE, LOAD, CHECK, RUN, ERR}.
- One sub-module, `prog_mem`: 16×8 register file with one synchronous write port, one combinational read port, and synchronous clear on `reset`.
- FSM, wr_ptr, and checksum accumulator live in `prog_loader`.

## Test plan
- Reset then idle 5 cycles → `cpu_reset` = 1, `loaded` = 0, `err` = 0; `instr` = 8'h00 for all 16 `adr` values.
- `load_req`, then bytes 8'h01..8'h10, then checksum 8'h88 → RUN; `cpu_reset` low one cycle after the checksum edge; `instr` at `adr` 4'hA = 8'h0B.
- Same load with checksum 8'h89 → ERR; `err` = 1, `cpu_reset` stays 1; memory holds 8'h01..8'h10.
- `in_valid` toggling 1,0,1,0 during LOAD → only beats with valid && ready are written; wr_ptr advances 1 per accepted beat; final memory is identical to the back-to-back case.
- `load_req` pulsed after 7 bytes, then a full 16+1 load of 8'hFF ×16 with checksum 8'hF0 → RUN, all words 8'hFF; `load_req` coinciding with `in_valid` shows `in_ready` = 0 that cycle.
- `reset` asserted after 9 bytes → IDLE next edge; all words 8'h00; `err` = 0.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared definitions for the 4-bit CPU program loader: memory geometry and
// the loader state encoding.
package td4_pkg;

  localparam int ADR_W     = 4;
  localparam int INSTR_W   = 8;
  localparam int MEM_DEPTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    RUN,
    ERR
  } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Host-to-loader byte stream: valid/ready handshake carrying program bytes.
interface prog_loader_if;
  import td4_pkg::*;

  logic [INSTR_W-1:0] in_data;
  logic               in_valid;
  logic               in_ready;

  // Host side drives bytes, loader side answers with ready.
  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/prog_mem.sv
// 16x8 instruction store: one synchronous write port, one combinational
// read port, cleared to an all-nop program on reset.
module prog_mem
  import td4_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADR_W-1:0]   wr_adr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [ADR_W-1:0]   rd_adr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] r_mem [MEM_DEPTH];

  // Write port; reset rewrites every word with the nop opcode.
  // NOTE: memories are normally left unreset; this one is cleared because
  // the CPU must see a defined nop program after reset, which forces a
  // flop-based register file rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[wr_adr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_adr];

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives 16 program bytes (plus an optional checksum)
// over a valid/ready stream, stores them in the instruction memory, and
// holds the CPU in reset until a verified program is present.
module prog_loader
  import td4_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  prog_loader_if.slave       in_bus,
  input  logic [ADR_W-1:0]   adr,
  output logic [INSTR_W-1:0] instr,
  output logic               cpu_reset,
  output logic               loaded,
  output logic               err
);

  loader_state_t      r_state;
  logic [ADR_W-1:0]   r_wr_ptr;
  logic [INSTR_W-1:0] r_sum;
  logic               r_cpu_reset;
  logic               r_loaded;
  logic               r_err;

  logic w_ready;
  logic w_accept;
  logic w_mem_we;
  logic w_last_byte;

  // A restart request takes priority over any byte offered the same cycle.
  assign w_ready     = ((r_state == LOAD) || (r_state == CHECK)) && !load_req;
  assign w_accept    = w_ready && in_bus.in_valid;
  assign w_mem_we    = w_accept && (r_state == LOAD);
  assign w_last_byte = (r_wr_ptr == ADR_W'(MEM_DEPTH - 1));

  // Loader FSM with wr_ptr, running checksum and registered status outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking assignments would make the order of
  // statements change the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_sum       <= '0;
      r_cpu_reset <= 1'b1;
      r_loaded    <= 1'b0;
      r_err       <= 1'b0;
    end else if (load_req) begin
      r_state     <= LOAD;
      r_wr_ptr    <= '0;
      r_sum       <= '0;
      r_cpu_reset <= 1'b1;
      r_loaded    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            r_sum    <= r_sum + in_bus.in_data;
            // Wraps to 0 after the last word; nothing reads it until restart.
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_last_byte) begin
              if (CHECK_EN) begin
                r_state <= CHECK;
              end else begin
                r_state     <= RUN;
                r_cpu_reset <= 1'b0;
                r_loaded    <= 1'b1;
              end
            end
          end
        end
        CHECK: begin
          if (w_accept) begin
            if (in_bus.in_data == r_sum) begin
              r_state     <= RUN;
              r_cpu_reset <= 1'b0;
              r_loaded    <= 1'b1;
            end else begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end
          end
        end
        // IDLE, RUN and ERR are left only through load_req or reset.
        default: begin
        end
      endcase
    end
  end

  prog_mem u_prog_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (w_mem_we),
    .wr_adr  (r_wr_ptr),
    .wr_data (in_bus.in_data),
    .rd_adr  (adr),
    .rd_data (instr)
  );

  assign in_bus.in_ready = w_ready;
  assign cpu_reset       = r_cpu_reset;
  assign loaded          = r_loaded;
  assign err             = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of full loads with known
// outcomes, hand sequences for the multi-cycle corners, and randomized
// loads checked against a byte-level model of the loader.
module tb_prog_loader;
  import td4_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_req;
  logic [3:0] adr;
  logic [7:0] instr;
  logic       cpu_reset;
  logic       loaded;
  logic       err;

  prog_loader_if bus ();

  prog_loader #(.CHECK_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_req  (load_req),
    .in_bus    (bus),
    .adr       (adr),
    .instr     (instr),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model of the instruction memory as the host expects it to be.
  logic [7:0] exp_mem [16];

  typedef struct {
    logic [127:0] data;        // byte i at [8*i +: 8]
    logic [7:0]   csum;
    logic         exp_loaded;
    logic         exp_err;
    logic         exp_cpu_reset;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All driving tasks start and end just after a falling edge.
  task automatic pulse_load_req();
    load_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Offer one byte until accepted (bounded); valid drops after acceptance.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      #1;
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("byte_accepted", 32'(ok), 32'd1);
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    send_byte(b);
  endtask

  task automatic check_mem(input string name);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      adr = 4'(i);
      #1;
      check($sformatf("%s mem[%0d]", name, i), 32'(instr), 32'(exp_mem[i]));
    end
  endtask

  task automatic check_status(input string name, input logic e_cr, input logic e_ld, input logic e_err);
    check({name, " cpu_reset"}, 32'(cpu_reset), 32'(e_cr));
    check({name, " loaded"},    32'(loaded),    32'(e_ld));
    check({name, " err"},       32'(err),       32'(e_err));
  endtask

  // Full load: restart, 16 bytes (gap < 0 means random 0..2 idle cycles
  // before each byte), then the checksum byte.
  task automatic load_program(input logic [7:0] d [16], input logic [7:0] csum,
                              input int gap, input string name);
    pulse_load_req();
    for (int i = 0; i < 16; i++) begin
      send_gap(d[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
      exp_mem[i] = d[i];
    end
    #1;
    check({name, " pre_csum cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({name, " pre_csum in_ready"},  32'(bus.in_ready), 32'd1);
    send_byte(csum);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] d [16];
    logic [7:0] s;
    logic [7:0] csum;
    bit         good;
    int         k;

    vecs[0] = '{128'h100F0E0D0C0B0A09_0807060504030201, 8'h88, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{128'h100F0E0D0C0B0A09_0807060504030201, 8'h89, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{{16{8'hFF}},                            8'hF0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{{16{8'h00}},                            8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{{8{16'h5AA5}},                          8'hF8, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{{8{16'h5AA5}},                          8'h00, 1'b0, 1'b1, 1'b1};

    reset        = 1'b1;
    load_req     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    adr          = 4'h0;
    foreach (exp_mem[i]) exp_mem[i] = 8'h00;

    // Reset, then five idle cycles: CPU held, nop program everywhere.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check_status("reset", 1'b1, 1'b0, 1'b0);
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check_mem("reset");

    // Table of full back-to-back loads with known outcomes.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++) d[i] = vecs[v].data[8*i +: 8];
      load_program(d, vecs[v].csum, 0, $sformatf("vec%0d", v));
      #1;
      check_status($sformatf("vec%0d", v), vecs[v].exp_cpu_reset,
                   vecs[v].exp_loaded, vecs[v].exp_err);
      check($sformatf("vec%0d in_ready", v), 32'(bus.in_ready), 32'd0);
      check_mem($sformatf("vec%0d", v));
    end

    // load_req from RUN: reset re-asserted after the edge, byte accepted next.
    for (int i = 0; i < 16; i++) d[i] = 8'(i + 1);
    load_program(d, 8'h88, 0, "run_setup");
    #1;
    check("run_setup cpu_reset", 32'(cpu_reset), 32'd0);
    check("run_setup instr[A]", 32'(instr), 32'(exp_mem[adr]));
    adr = 4'hA;
    #1;
    check("run instr[A]", 32'(instr), 32'h0B);
    pulse_load_req();
    #1;
    check_status("restart_from_run", 1'b1, 1'b0, 1'b0);
    check("restart_from_run in_ready", 32'(bus.in_ready), 32'd1);
    // Write-to-read: byte at wr_ptr 0 visible the cycle after its edge.
    adr = 4'h0;
    send_byte(8'h3C);
    #1;
    check("write_to_read instr[0]", 32'(instr), 32'h3C);
    adr = 4'h1;
    #1;
    check("write_to_read instr[1] old", 32'(instr), 32'h02);

    // Toggling valid (one idle cycle per byte) must give the same memory.
    load_program(d, 8'h88, 1, "toggle");
    #1;
    check_status("toggle", 1'b0, 1'b1, 1'b0);
    check_mem("toggle");

    // Abort after 7 bytes; load_req with valid high shows in_ready low.
    pulse_load_req();
    for (int i = 0; i < 7; i++) begin
      send_byte(8'h55);
      exp_mem[i] = 8'h55;
    end
    load_req     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    #1;
    check("abort in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    load_req     = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_status("abort", 1'b1, 1'b0, 1'b0);
    check_mem("abort");
    for (int i = 0; i < 16; i++) begin
      send_byte(8'hFF);
      exp_mem[i] = 8'hFF;
    end
    send_byte(8'hF0);
    #1;
    check_status("after_abort", 1'b0, 1'b1, 1'b0);
    check_mem("after_abort");

    // Reset after 9 bytes: IDLE on that edge, memory cleared.
    pulse_load_req();
    for (int i = 0; i < 9; i++) send_byte(8'h77);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_status("mid_reset", 1'b1, 1'b0, 1'b0);
    check("mid_reset in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    foreach (exp_mem[i]) exp_mem[i] = 8'h00;
    check_mem("mid_reset");

    // Randomized loads with optional aborts, against the byte-level model.
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        pulse_load_req();
        k = int'($urandom_range(1, 15));
        for (int i = 0; i < k; i++) begin
          s = 8'($urandom);
          send_gap(s, int'($urandom_range(0, 2)));
          exp_mem[i] = s;
        end
        #1;
        check_status($sformatf("rnd%0d partial", n), 1'b1, 1'b0, 1'b0);
      end
      s = 8'h00;
      for (int i = 0; i < 16; i++) begin
        d[i] = 8'($urandom);
        s    = s + d[i];
      end
      good = bit'($urandom_range(0, 1));
      csum = good ? s : s + 8'($urandom_range(1, 255));
      load_program(d, csum, -1, $sformatf("rnd%0d", n));
      #1;
      check_status($sformatf("rnd%0d", n), !good, good, !good);
      check_mem($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
